multicycle_ctrl: RTL and testbench

//  Multi-cycle control sequencer for the RV32I core. Steps each instruction through

---
 rtl/multicycle_ctrl_pkg.sv | 38 +++
 rtl/multicycle_ctrl_wait_timer.sv | 26 ++
 rtl/multicycle_ctrl.sv | 93 +++++++++
 tb/tb_multicycle_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the RV32I multi-cycle control sequencer: state codes,
// PC source select and the decoder's memory-op encoding.
package multicycle_ctrl_pkg;

    typedef logic [2:0] ctrl_state_t;

    localparam ctrl_state_t ST_FETCH  = 3'd0;
    localparam ctrl_state_t ST_DECODE = 3'd1;
    localparam ctrl_state_t ST_EXEC   = 3'd2;
    localparam ctrl_state_t ST_MEM    = 3'd3;
    localparam ctrl_state_t ST_WB     = 3'd4;
    localparam ctrl_state_t ST_FAULT  = 3'd5;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_ALU    = 2'b01,
        PC_BRANCH = 2'b10
    } pc_sel_e;

    typedef enum logic [1:0] {
        MEM_NOP     = 2'b00,
        MEM_LOAD    = 2'b01,
        MEM_STORE   = 2'b10,
        MEM_ILLEGAL = 2'b11
    } mem_op_e;

    // Jumps win over branches; a not-taken branch falls through to PC+4.
    function automatic pc_sel_e pcSelect(input logic jump, input logic isBranch,
                                         input logic taken);
        if (jump)
            return PC_ALU;
        else if (isBranch && taken)
            return PC_BRANCH;
        else
            return PC_PLUS4;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_wait_timer.sv
// Wait-state counter shared by the FETCH and MEM handshakes; o_expired flags
// that the current non-ready cycle is the last one allowed.
module ctrl_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam int W = $clog2(MEM_TIMEOUT + 1);

    logic [W-1:0] r_count;

    assign o_expired = (r_count == W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || i_clear)
            r_count <= '0;
        else if (i_en && !o_expired)
            r_count <= r_count + W'(1);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> WB with
// memory handshakes, retired-instruction counter and a sticky FAULT state.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             ir_we,
    input  logic             dec_valid,
    input  logic [1:0]       dec_mem_op,
    input  logic             dec_reg_we,
    input  logic             dec_jump,
    input  logic             dec_is_branch,
    input  logic             branch_taken,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             rf_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic [CNT_W-1:0] instret,
    output logic             fault
);

    ctrl_state_t      r_state;
    ctrl_state_t      w_next;
    pc_sel_e          r_pc_sel;
    logic [CNT_W-1:0] r_instret;
    logic             w_expired;
    logic             w_timerEn;
    logic             w_timerClear;

    assign w_timerEn    = ((r_state == ST_FETCH) && !imem_ready) ||
                          ((r_state == ST_MEM)   && !dmem_ready);
    assign w_timerClear = (w_next != r_state);

    ctrl_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_timerClear),
        .i_en      (w_timerEn),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH:  if (imem_ready)      w_next = ST_DECODE;
                       else if (w_expired)  w_next = ST_FAULT;
            ST_DECODE: w_next = dec_valid ? ST_EXEC : ST_FAULT;
            ST_EXEC:   if (dec_mem_op == MEM_ILLEGAL) w_next = ST_FAULT;
                       else if (dec_mem_op != MEM_NOP) w_next = ST_MEM;
                       else                            w_next = ST_WB;
            ST_MEM:    if (dmem_ready)      w_next = ST_WB;
                       else if (w_expired)  w_next = ST_FAULT;
            ST_WB:     w_next = ST_FETCH;
            ST_FAULT:  w_next = ST_FAULT;
            default:   w_next = ST_FAULT;
        endcase
    end

    // pc_sel is only captured on a legal EXEC exit so a fault leaves it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_pc_sel  <= PC_PLUS4;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_EXEC && w_next != ST_FAULT)
                r_pc_sel <= pcSelect(dec_jump, dec_is_branch, branch_taken);
            if (r_state == ST_WB)
                r_instret <= r_instret + CNT_W'(1);
        end
    end

    // Strobes are masked by rst so an outstanding request drops immediately.
    assign imem_req = !rst && (r_state == ST_FETCH);
    assign ir_we    = imem_req && imem_ready;
    assign dmem_req = !rst && (r_state == ST_MEM);
    assign dmem_we  = dmem_req && (dec_mem_op == MEM_STORE);
    assign pc_we    = !rst && (r_state == ST_WB);
    assign rf_we    = pc_we && dec_reg_we;
    assign fault    = !rst && (r_state == ST_FAULT);
    assign pc_sel   = r_pc_sel;
    assign instret  = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl: each instruction is
// expanded into its expected per-cycle strobe trace from the sequencing rules.
module tb_multicycle_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CW      = 4;

    localparam logic [6:0] E_IREQ  = 7'b1000000;
    localparam logic [6:0] E_IRWE  = 7'b0100000;
    localparam logic [6:0] E_DREQ  = 7'b0010000;
    localparam logic [6:0] E_DWE   = 7'b0001000;
    localparam logic [6:0] E_RFWE  = 7'b0000100;
    localparam logic [6:0] E_PCWE  = 7'b0000010;
    localparam logic [6:0] E_FAULT = 7'b0000001;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_req, imem_ready, ir_we;
    logic          dec_valid, dec_reg_we, dec_jump, dec_is_branch, branch_taken;
    logic [1:0]    dec_mem_op;
    logic          dmem_req, dmem_we, dmem_ready;
    logic          rf_we, pc_we, fault;
    logic [1:0]    pc_sel;
    logic [CW-1:0] instret;

    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] modelCnt = '0;
    logic [1:0]    modelSel = 2'b00;

    multicycle_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_ready    (imem_ready),
        .ir_we         (ir_we),
        .dec_valid     (dec_valid),
        .dec_mem_op    (dec_mem_op),
        .dec_reg_we    (dec_reg_we),
        .dec_jump      (dec_jump),
        .dec_is_branch (dec_is_branch),
        .branch_taken  (branch_taken),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_ready    (dmem_ready),
        .rf_we         (rf_we),
        .pc_we         (pc_we),
        .pc_sel        (pc_sel),
        .instret       (instret),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock: drive readies, compare everything at the falling edge.
    task automatic applyStimulus(input logic iRdy, input logic dRdy,
                                 input logic [6:0] strobes, input string tag);
        imem_ready = iRdy;
        dmem_ready = dRdy;
        @(negedge clk);
        checkOutput(tag,
                    {19'd0, instret, pc_sel,
                     imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, fault},
                    {19'd0, modelCnt, modelSel, strobes});
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input string tag);
        rst        = 1'b1;
        imem_ready = rnd();
        dmem_ready = rnd();
        @(negedge clk);
        checkOutput(tag, {25'd0, imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, fault},
                    32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        modelCnt = '0;
        modelSel = 2'b00;
    endtask

    task automatic faultTail(input string tag);
        for (int i = 0; i < 3; i++)
            applyStimulus(rnd(), rnd(), E_FAULT, tag);
        doReset("resetFromFault");
    endtask

    task automatic setDecoder(input logic valid, input logic [1:0] memop,
                              input logic regwe, input logic jump,
                              input logic isbr, input logic taken);
        dec_valid     = valid;
        dec_mem_op    = memop;
        dec_reg_we    = regwe;
        dec_jump      = jump;
        dec_is_branch = isbr;
        branch_taken  = taken;
    endtask

    // fw/mw are the number of non-ready cycles before imem/dmem ready.
    task automatic runInstr(input int fw, input int mw, input logic valid,
                            input logic [1:0] memop, input logic regwe,
                            input logic jump, input logic isbr, input logic taken);
        logic [1:0] sel;
        logic [6:0] memStrobes;
        setDecoder(valid, memop, regwe, jump, isbr, taken);
        sel        = jump ? 2'b01 : ((isbr && taken) ? 2'b10 : 2'b00);
        memStrobes = E_DREQ | ((memop == 2'b10) ? E_DWE : 7'b0);
        for (int i = 0; i < fw && i < TIMEOUT; i++)
            applyStimulus(1'b0, rnd(), E_IREQ, "fetchWait");
        if (fw >= TIMEOUT) begin
            faultTail("fetchTimeout");
            return;
        end
        applyStimulus(1'b1, rnd(), E_IREQ | E_IRWE, "fetchAccept");
        applyStimulus(rnd(), rnd(), 7'b0, "decode");
        if (!valid) begin
            faultTail("illegalOpcode");
            return;
        end
        applyStimulus(rnd(), rnd(), 7'b0, "exec");
        if (memop == 2'b11) begin
            faultTail("illegalMemOp");
            return;
        end
        modelSel = sel;
        if (memop != 2'b00) begin
            for (int i = 0; i < mw && i < TIMEOUT; i++)
                applyStimulus(rnd(), 1'b0, memStrobes, "memWait");
            if (mw >= TIMEOUT) begin
                faultTail("memTimeout");
                return;
            end
            applyStimulus(rnd(), 1'b1, memStrobes, "memAccept");
        end
        applyStimulus(rnd(), rnd(), (regwe ? E_RFWE : 7'b0) | E_PCWE, "writeback");
        modelCnt = modelCnt + 1'b1;
    endtask

    task automatic randomLegal();
        int kind;
        kind = $urandom_range(0, 4);
        case (kind)
            0: runInstr($urandom_range(0, 3), 0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
            1: runInstr($urandom_range(0, 3), $urandom_range(0, 3), 1'b1, 2'b01, 1'b1,
                        1'b0, 1'b0, 1'b0);
            2: runInstr($urandom_range(0, 3), $urandom_range(0, 3), 1'b1, 2'b10, 1'b0,
                        1'b0, 1'b0, 1'b0);
            3: runInstr($urandom_range(0, 3), 0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, rnd());
            default: runInstr($urandom_range(0, 3), 0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        endcase
    endtask

    task automatic randomAny();
        int pick;
        pick = $urandom_range(0, 19);
        case (pick)
            0: runInstr(TIMEOUT + $urandom_range(0, 2), 0, 1'b1, 2'b00, 1'b1,
                        1'b0, 1'b0, 1'b0);
            1: runInstr($urandom_range(0, 3), TIMEOUT, 1'b1, 2'b01, 1'b1,
                        1'b0, 1'b0, 1'b0);
            2: runInstr($urandom_range(0, 3), 0, 1'b0, 2'($urandom_range(0, 2)), rnd(),
                        rnd(), 1'b0, 1'b0);
            3: runInstr($urandom_range(0, 3), 0, 1'b1, 2'b11, rnd(), 1'b0, rnd(), rnd());
            default: randomLegal();
        endcase
    endtask

    initial begin
        setDecoder(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst        = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        @(posedge clk);
        #1;
        doReset("resetState");

        runInstr(0, 0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        runInstr(0, 3, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        runInstr(0, 0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        runInstr(0, 0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        runInstr(0, 0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        runInstr(2, 3, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        runInstr(1, 0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        runInstr(TIMEOUT, 0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        runInstr(0, TIMEOUT, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);

        while (modelCnt != {CW{1'b1}})
            randomLegal();
        setDecoder(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, E_IREQ | E_IRWE, "fetchAccept");
        applyStimulus(1'b0, 1'b0, 7'b0, "decode");
        applyStimulus(1'b0, 1'b0, 7'b0, "exec");
        applyStimulus(1'b0, 1'b0, E_DREQ, "memWait");
        doReset("resetMidMem");
        applyStimulus(1'b0, 1'b0, E_IREQ, "fetchAfterReset");
        doReset("resetIdle");

        for (int i = 0; i < (1 << CW); i++)
            randomLegal();
        checkOutput("instretWrap", {28'd0, instret}, 32'd0);

        for (int i = 0; i < 250; i++)
            randomAny();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
